// File: rtl/frame_delay_pkg.sv
// Shared types and constants for the frame delay/alignment buffer.
//   fd_state_t   : start-up gating state of the read side
//   FRAM_LEN_NR  : egress frame length in clk cycles, NR build
//   FRAM_LEN_LTE : egress frame length in clk cycles, LTE build
package frame_delay_pkg;

   typedef enum logic [1:0] {
      WAIT_WR = 2'd0,
      WAIT_RD = 2'd1,
      RUN     = 2'd2
   } fd_state_t;

   localparam int unsigned FRAM_LEN_NR  = 4915200;
   localparam int unsigned FRAM_LEN_LTE = 2457600;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one write port and one always-enabled read port.
// Written every cycle; the read data is registered RAM_LAT times so the
// tools can map the output stages onto the UltraRAM/BRAM pipeline registers.
//   clk      : clock
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : read data, RAM_LAT cycles after rd_addr (old data on collision)
module sdp_ram #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 13,
   parameter int unsigned RAM_LAT = 2
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem     [2**ADDR_W];
   logic [DATA_W-1:0] rd_pipe [RAM_LAT];

   always_ff @(posedge clk) begin
      mem[wr_addr] <= wr_data;
      rd_pipe[0]   <= mem[rd_addr];
      for (int i = 1; i < RAM_LAT; i++) begin
         rd_pipe[i] <= rd_pipe[i-1];
      end
   end

   assign rd_data = rd_pipe[RAM_LAT-1];

endmodule

// File: rtl/frame_delay_align.sv
// Frame delay/alignment buffer between the deframer and the DFE.
// The ingress stream is written into a circular buffer, address 0 at the
// ingress frame header. The egress side reads from address 0 at every egress
// header event (timing pulse, or a regenerated header when the pulse is
// missing), so the delay is set by the distance between the two headers.
//   clk          : clock
//   rst          : asynchronous reset, active low
//   i_fram_hd    : ingress frame header, co-timed with sample 0 on i_data
//   i_data       : ingress sample, one per cycle
//   i_adjust_hd  : egress alignment pulse from timing
//   i_clr_err    : clears the sticky error flags
//   o_fram_hd    : egress header, co-timed with sample 0 on o_data
//   o_xant_hd    : last sample of each antenna group
//   o_data       : delayed sample, zero while o_valid is low
//   o_valid      : egress stream valid
//   o_delay      : write pointer latched at the last egress header event
//   o_err_ovf    : sticky, delay exceeded the buffer depth
//   o_err_miss   : sticky, header regenerated for a missing i_adjust_hd
//   o_err_mis    : sticky, i_adjust_hd arrived off the frame boundary
//
// state   | meaning
// WAIT_WR | no ingress header seen yet, buffer content meaningless
// WAIT_RD | buffer filling, waiting for the first egress header event
// RUN     | read side aligned, egress stream valid (left only by reset)
module frame_delay_align
   import frame_delay_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 13,
   parameter int unsigned NUM_ANT  = 4,
   parameter int unsigned FRAM_LEN = FRAM_LEN_NR,
   parameter int unsigned RAM_LAT  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_fram_hd,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_adjust_hd,
   input  logic              i_clr_err,
   output logic              o_fram_hd,
   output logic              o_xant_hd,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_delay,
   output logic              o_err_ovf,
   output logic              o_err_miss,
   output logic              o_err_mis
);

   localparam int unsigned CNT_W = $clog2(FRAM_LEN);
   localparam int unsigned ANT_W = $clog2(NUM_ANT);

   localparam logic [CNT_W-1:0]  RD_LAST  = CNT_W'(FRAM_LEN - 1);
   localparam logic [ANT_W-1:0]  ANT_LAST = ANT_W'(NUM_ANT - 1);
   localparam logic [ADDR_W:0]   AGE_MAX  = {1'b1, {ADDR_W{1'b0}}};

   fd_state_t         state;
   fd_state_t         state_nxt;

   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W-1:0] waddr_eff;
   logic [ADDR_W:0]   wr_age;
   logic [ADDR_W:0]   wr_age_eff;

   logic [CNT_W-1:0]  rd_cnt;
   logic              rd_last;
   logic              hd_ev;
   logic [ADDR_W-1:0] raddr;
   logic [ADDR_W-1:0] raddr_eff;

   logic              set_ovf;
   logic              set_miss;
   logic              set_mis;

   logic [RAM_LAT-1:0] hd_pipe;
   logic [RAM_LAT-1:0] vld_pipe;
   logic [DATA_W-1:0]  ram_q;
   logic [ANT_W-1:0]   xant_cnt;
   logic [ANT_W-1:0]   xant_nxt;

   // The header cycle itself addresses slot 0, so pointers use the forced
   // value combinationally and the register holds the next address.
   assign waddr_eff  = i_fram_hd ? '0 : waddr;
   assign wr_age_eff = i_fram_hd ? '0 : wr_age;

   assign rd_last   = (rd_cnt == RD_LAST);
   assign hd_ev     = i_adjust_hd | rd_last;
   assign raddr_eff = hd_ev ? '0 : raddr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         waddr  <= '0;
         wr_age <= '0;
      end else begin
         waddr  <= waddr_eff + ADDR_W'(1);
         wr_age <= (wr_age_eff == AGE_MAX) ? AGE_MAX : wr_age_eff + (ADDR_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_cnt  <= '0;
         raddr   <= '0;
         o_delay <= '0;
      end else begin
         rd_cnt <= hd_ev ? '0 : rd_cnt + CNT_W'(1);
         raddr  <= raddr_eff + ADDR_W'(1);
         // Registered pointer, so a co-timed ingress header still reports
         // the distance covered by the previous frame.
         if (hd_ev) begin
            o_delay <= waddr;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= WAIT_WR;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_WR: if (i_fram_hd) state_nxt = WAIT_RD;
         WAIT_RD: if (hd_ev)     state_nxt = RUN;
         RUN:                    state_nxt = RUN;
         default:                state_nxt = WAIT_WR;
      endcase
   end

   // Overflow needs a valid ingress reference; miss/misalignment are only
   // meaningful once the egress frame timing has been established.
   always_comb begin
      set_ovf  = hd_ev && (state != WAIT_WR) && (wr_age == AGE_MAX);
      set_miss = rd_last && !i_adjust_hd && (state == RUN);
      set_mis  = i_adjust_hd && (state == RUN) && (rd_cnt != '0) && !rd_last;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_err_ovf  <= 1'b0;
         o_err_miss <= 1'b0;
         o_err_mis  <= 1'b0;
      end else begin
         if (set_ovf)        o_err_ovf  <= 1'b1;
         else if (i_clr_err) o_err_ovf  <= 1'b0;
         if (set_miss)       o_err_miss <= 1'b1;
         else if (i_clr_err) o_err_miss <= 1'b0;
         if (set_mis)        o_err_mis  <= 1'b1;
         else if (i_clr_err) o_err_mis  <= 1'b0;
      end
   end

   sdp_ram #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .RAM_LAT (RAM_LAT)
   ) u_ram (
      .clk     (clk),
      .wr_addr (waddr_eff),
      .wr_data (i_data),
      .rd_addr (raddr_eff),
      .rd_data (ram_q)
   );

   // Header and valid ride alongside the RAM read pipeline. Valid is taken
   // from the next state so the header cycle entering RUN is already valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hd_pipe  <= '0;
         vld_pipe <= '0;
      end else begin
         hd_pipe[0]  <= hd_ev;
         vld_pipe[0] <= (state_nxt == RUN);
         for (int i = 1; i < RAM_LAT; i++) begin
            hd_pipe[i]  <= hd_pipe[i-1];
            vld_pipe[i] <= vld_pipe[i-1];
         end
      end
   end

   // xant_cnt is the antenna index of the sample currently on o_data.
   assign xant_nxt = hd_pipe[RAM_LAT-1] ? '0 : xant_cnt + ANT_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_fram_hd <= 1'b0;
         o_valid   <= 1'b0;
         o_data    <= '0;
         o_xant_hd <= 1'b0;
         xant_cnt  <= '0;
      end else begin
         o_fram_hd <= hd_pipe[RAM_LAT-1];
         o_valid   <= vld_pipe[RAM_LAT-1];
         o_data    <= vld_pipe[RAM_LAT-1] ? ram_q : '0;
         o_xant_hd <= vld_pipe[RAM_LAT-1] && (xant_nxt == ANT_LAST);
         xant_cnt  <= xant_nxt;
      end
   end

endmodule
